mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch requester (F stage) and the data requester (M stage, driven by the E/M pipeline register outputs).
- Arbitrates between the two, sequences the memory handshake, and forms byte enables and store data from funct3M and the address low bits.
- Sign/zero-extends load data and raises one global pipeline freeze until every pending access of the current cycle is served.
- Sits between the pipeline registers/hazard logic and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_lane_align.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM states,
// access-size codes and architectural constants.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_INST = 2'd2
    } arb_state_e;

    // funct3[1:0] gives the access size, funct3[2] selects zero-extension
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0]  LOAD_OP_DEF = 2'b01;
    localparam logic [31:0] NOP_INSTR   = 32'h00000013;

    function automatic logic [1:0] access_size(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: store enables/replication,
// load extraction with sign/zero extension, and misalignment detection.
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  rd_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_byte;
    logic        sign_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_lane[gi] = rdata_in[8*gi +: 8];
    end

    assign byte_sel  = rd_lane[addr_lo];
    assign half_sel  = addr_lo[1] ? rdata_in[31:16] : rdata_in[15:0];
    assign sign_byte = ~funct3[2] & byte_sel[7];
    assign sign_half = ~funct3[2] & half_sel[15];

    always_comb begin
        be        = 4'b1111;
        wdata     = wdata_in;
        load_data = rdata_in;
        misalign  = 1'b0;
        case (access_size(funct3))
            SZ_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{wdata_in[7:0]}};
                load_data = {{24{sign_byte}}, byte_sel};
            end
            SZ_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{wdata_in[15:0]}};
                load_data = {{16{sign_half}}, half_sel};
                misalign  = addr_lo[0];
            end
            default: begin
                misalign  = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the M-stage
// data access; data wins, and StallMem freezes the pipeline until both are served.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter logic [1:0] LOAD_OP = LOAD_OP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ireq,
    input  logic [31:0]       PCF,
    input  logic              MemWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic [2:0]        funct3M,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       InstrF,
    output logic [31:0]       ReadDataM,
    output logic              StallMem,
    output logic              MisalignM
);

    arb_state_e        state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q,    mem_be_d;
    logic [31:0]       instr_q,     instr_d;
    logic [31:0]       rdata_q,     rdata_d;
    logic              misalign_q,  misalign_d;
    logic              iserved_q,   iserved_d;
    logic              dserved_q,   dserved_d;

    logic              dreq;
    logic              dpend;
    logic              ipend;
    logic              stall;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_load;
    logic              lane_misalign;
    logic              unused_pc_lo;

    // Fetch addresses are always word aligned; the low PC bits carry no meaning here
    assign unused_pc_lo = ^PCF[1:0];

    assign dreq  = MemWriteM | (ResultSrcM == LOAD_OP);
    assign dpend = dreq & ~dserved_q;
    assign ipend = ireq & ~iserved_q;
    assign stall = dpend | ipend;

    mem_lane_align u_lane (
        .addr_lo   (ALUResultM[1:0]),
        .funct3    (funct3M),
        .wdata_in  (WriteDataM),
        .rdata_in  (mem_rdata),
        .be        (lane_be),
        .wdata     (lane_wdata),
        .load_data (lane_load),
        .misalign  (lane_misalign)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        instr_d     = instr_q;
        rdata_d     = rdata_q;
        misalign_d  = misalign_q;
        iserved_d   = iserved_q;
        dserved_d   = dserved_q;

        // Pipeline advances this edge: the next instruction pair starts fresh
        if (!stall) begin
            iserved_d  = 1'b0;
            dserved_d  = 1'b0;
            misalign_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (dpend && lane_misalign) begin
                    misalign_d = 1'b1;
                    rdata_d    = '0;
                    dserved_d  = 1'b1;
                end else if (dpend) begin
                    state_d     = ST_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWriteM;
                    mem_addr_d  = {ALUResultM[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = lane_wdata;
                    mem_be_d    = lane_be;
                end else if (ipend) begin
                    state_d     = ST_INST;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {PCF[ADDR_W-1:2], 2'b00};
                    mem_be_d    = 4'b1111;
                end
            end
            ST_DATA: begin
                if (mem_ready) begin
                    if (!MemWriteM) begin
                        rdata_d = lane_load;
                    end
                    dserved_d = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'b0000;
                    state_d   = ST_IDLE;
                end
            end
            ST_INST: begin
                if (mem_ready) begin
                    instr_d   = mem_rdata;
                    iserved_d = 1'b1;
                    mem_req_d = 1'b0;
                    mem_be_d  = 4'b0000;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
            instr_q     <= NOP_INSTR;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
            iserved_q   <= 1'b0;
            dserved_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            instr_q     <= instr_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
            iserved_q   <= iserved_d;
            dserved_q   <= dserved_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign InstrF    = instr_q;
    assign ReadDataM = rdata_q;
    assign StallMem  = stall;
    assign MisalignM = misalign_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scripted memory responder serves each
// request while a queue of expected values is popped as results appear.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ireq;
    logic [31:0] PCF;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  funct3M;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] InstrF;
    logic [31:0] ReadDataM;
    logic        StallMem;
    logic        MisalignM;

    int          total = 0;
    int          bad = 0;
    int          stall_cnt = 0;
    int          s0;
    logic [31:0] last_wdata;

    logic [31:0] exp_val_q [$];
    string       exp_tag_q [$];

    mem_port_arbiter #(.ADDR_W(32), .LOAD_OP(2'b01)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ireq       (ireq),
        .PCF        (PCF),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .funct3M    (funct3M),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .InstrF     (InstrF),
        .ReadDataM  (ReadDataM),
        .StallMem   (StallMem),
        .MisalignM  (MisalignM)
    );

    always #5 clk = ~clk;

    // Stall cycles are counted just after each falling edge, once inputs have settled
    always @(negedge clk) begin
        #1;
        if (StallMem === 1'b1) stall_cnt <= stall_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_tag_q.push_back(tag);
        exp_val_q.push_back(v);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_val_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty observed=%h expected=none", obs);
        end else begin
            t = exp_tag_q.pop_front();
            e = exp_val_q.pop_front();
            chk(t, obs, e);
        end
    endtask

    // Waits for a request, checks addr/we/be against the queue, holds it for
    // lat extra cycles, then returns rdata with a one-cycle ready pulse.
    task automatic serve(input logic [31:0] rdata, input int lat);
        int waited = 0;
        while (mem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (mem_req !== 1'b1) begin
            total++;
            bad++;
            $error("FAIL serve_timeout observed=%b expected=1", mem_req);
        end
        sb_check(mem_addr);
        sb_check({31'b0, mem_we});
        sb_check({28'b0, mem_be});
        last_wdata = mem_wdata;
        repeat (lat) begin
            @(negedge clk);
            chk("req_held", {31'b0, mem_req}, 32'd1);
        end
        mem_rdata = rdata;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic drop_reqs();
        ireq       = 1'b0;
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
    endtask

    task automatic data_op(input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        MemWriteM  = wr;
        ResultSrcM = wr ? 2'b00 : 2'b01;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
    endtask

    initial begin
        rst_n = 1'b0; ireq = 1'b0; PCF = '0; MemWriteM = 1'b0; ResultSrcM = '0;
        ALUResultM = '0; WriteDataM = '0; funct3M = '0; mem_ready = 1'b0; mem_rdata = '0;
        last_wdata = '0;
        repeat (2) @(negedge clk);

        chk("rst_req",    {31'b0, mem_req},  32'd0);
        chk("rst_we",     {31'b0, mem_we},   32'd0);
        chk("rst_be",     {28'b0, mem_be},   32'd0);
        chk("rst_addr",   mem_addr,          32'd0);
        chk("rst_wdata",  mem_wdata,         32'd0);
        chk("rst_instr",  InstrF,            32'h00000013);
        chk("rst_rdata",  ReadDataM,         32'd0);
        chk("rst_mis",    {31'b0, MisalignM}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // fetch only
        s0 = stall_cnt;
        ireq = 1'b1; PCF = 32'h104;
        sb_push("f_addr", 32'h104); sb_push("f_we", 0); sb_push("f_be", 32'hF);
        sb_push("f_instr", 32'h00500093); sb_push("f_stall", 2);
        serve(32'h00500093, 0);
        drop_reqs();
        @(negedge clk);
        sb_check(InstrF);
        sb_check(32'(stall_cnt - s0));

        // lw and fetch together: data first
        s0 = stall_cnt;
        ireq = 1'b1; PCF = 32'h300;
        data_op(1'b0, 3'b010, 32'h200, 32'h0);
        sb_push("lw_addr", 32'h200); sb_push("lw_we", 0); sb_push("lw_be", 32'hF);
        sb_push("if_addr", 32'h300); sb_push("if_we", 0); sb_push("if_be", 32'hF);
        sb_push("lw_data", 32'hDEADBEEF); sb_push("if_instr", 32'h00A00113); sb_push("both_stall", 4);
        serve(32'hDEADBEEF, 0);
        serve(32'h00A00113, 0);
        drop_reqs();
        @(negedge clk);
        sb_check(ReadDataM);
        sb_check(InstrF);
        sb_check(32'(stall_cnt - s0));

        // sb to the top lane, slow memory
        s0 = stall_cnt;
        data_op(1'b1, 3'b000, 32'h203, 32'h000000AB);
        sb_push("sb_addr", 32'h200); sb_push("sb_we", 1); sb_push("sb_be", 32'h8);
        sb_push("sb_wdata", 32'hABABABAB); sb_push("sb_rd_keep", 32'hDEADBEEF); sb_push("sb_stall", 4);
        serve(32'hFFFFFFFF, 2);
        sb_check(last_wdata);
        drop_reqs();
        @(negedge clk);
        sb_check(ReadDataM);
        sb_check(32'(stall_cnt - s0));

        // sh to the upper half
        data_op(1'b1, 3'b001, 32'h402, 32'h00001234);
        sb_push("sh_addr", 32'h400); sb_push("sh_we", 1); sb_push("sh_be", 32'hC);
        sb_push("sh_wdata", 32'h12341234);
        serve(32'h0, 1);
        sb_check(last_wdata);
        drop_reqs();
        @(negedge clk);

        // byte/half loads from word 0x0080FF00
        data_op(1'b0, 3'b000, 32'h202, 32'h0);
        sb_push("lb_addr", 32'h200); sb_push("lb_we", 0); sb_push("lb_be", 32'h4);
        sb_push("lb_data", 32'hFFFFFF80);
        serve(32'h0080FF00, 0);
        drop_reqs();
        @(negedge clk);
        sb_check(ReadDataM);

        data_op(1'b0, 3'b101, 32'h202, 32'h0);
        sb_push("lhu_addr", 32'h200); sb_push("lhu_we", 0); sb_push("lhu_be", 32'hC);
        sb_push("lhu_data", 32'h00000080);
        serve(32'h0080FF00, 0);
        drop_reqs();
        @(negedge clk);
        sb_check(ReadDataM);

        data_op(1'b0, 3'b100, 32'h201, 32'h0);
        sb_push("lbu_addr", 32'h200); sb_push("lbu_we", 0); sb_push("lbu_be", 32'h2);
        sb_push("lbu_data", 32'h000000FF);
        serve(32'h0080FF00, 0);
        drop_reqs();
        @(negedge clk);
        sb_check(ReadDataM);

        data_op(1'b0, 3'b001, 32'h200, 32'h0);
        sb_push("lh_addr", 32'h200); sb_push("lh_we", 0); sb_push("lh_be", 32'h3);
        sb_push("lh_data", 32'hFFFFFF00);
        serve(32'h0080FF00, 0);
        drop_reqs();
        @(negedge clk);
        sb_check(ReadDataM);

        // misaligned lw: flagged, no memory access, one stall cycle
        s0 = stall_cnt;
        data_op(1'b0, 3'b010, 32'h102, 32'h0);
        sb_push("mis_flag", 1); sb_push("mis_rdata", 0); sb_push("mis_noreq", 0); sb_push("mis_stall_now", 0);
        sb_push("mis_clear", 0); sb_push("mis_noreq2", 0); sb_push("mis_stall", 1);
        @(negedge clk);
        sb_check({31'b0, MisalignM});
        sb_check(ReadDataM);
        sb_check({31'b0, mem_req});
        sb_check({31'b0, StallMem});
        drop_reqs();
        @(negedge clk);
        sb_check({31'b0, MisalignM});
        sb_check({31'b0, mem_req});
        sb_check(32'(stall_cnt - s0));

        // stray ready while idle must be ignored
        mem_rdata = 32'hBAD0BAD0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        chk("stray_instr", InstrF, 32'h00A00113);
        chk("stray_rdata", ReadDataM, 32'h0);
        chk("stray_req",   {31'b0, mem_req}, 32'd0);

        // reset in the middle of a data access
        ireq = 1'b1; PCF = 32'h500;
        data_op(1'b0, 3'b010, 32'h400, 32'h0);
        @(negedge clk);
        chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",   {31'b0, mem_req}, 32'd0);
        chk("arst_addr",  mem_addr,         32'd0);
        chk("arst_be",    {28'b0, mem_be},  32'd0);
        chk("arst_instr", InstrF,           32'h00000013);
        chk("arst_rdata", ReadDataM,        32'd0);
        chk("arst_stall", {31'b0, StallMem}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        sb_push("r_lw_addr", 32'h400); sb_push("r_lw_we", 0); sb_push("r_lw_be", 32'hF);
        sb_push("r_if_addr", 32'h500); sb_push("r_if_we", 0); sb_push("r_if_be", 32'hF);
        sb_push("r_lw_data", 32'h11223344); sb_push("r_instr", 32'h00108093); sb_push("r_stall_end", 0);
        serve(32'h11223344, 0);
        serve(32'h00108093, 0);
        drop_reqs();
        @(negedge clk);
        sb_check(ReadDataM);
        sb_check(InstrF);
        sb_check({31'b0, StallMem});

        chk("sb_drain", 32'(exp_val_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
